// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60), colour bus width and named colours
// used by the sync generator, its interface and the pixel renderer.
package vga_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_RGB_W = 3;

    typedef enum logic [VGA_RGB_W-1:0] {
        COLOUR_BLACK   = 3'b000,
        COLOUR_BLUE    = 3'b001,
        COLOUR_GREEN   = 3'b010,
        COLOUR_CYAN    = 3'b011,
        COLOUR_RED     = 3'b100,
        COLOUR_MAGENTA = 3'b101,
        COLOUR_YELLOW  = 3'b110,
        COLOUR_WHITE   = 3'b111
    } colour_e;

    // True when value lies in the half-open window [lo, lo+len).
    function automatic logic inWindow(input int value, input int lo, input int len);
        return (value >= lo) && (value < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bundle between the VGA timing generator (master) and the pixel renderer (slave).
interface vga_sync_gen_if #(
    parameter int CNT_W = 10,
    parameter int RGB_W = vga_pkg::VGA_RGB_W
);
    logic [RGB_W-1:0] rgb_in;
    logic             p_tick;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             video_on;
    logic             line_start;
    logic             frame_start;
    logic             hsync;
    logic             vsync;
    logic [RGB_W-1:0] rgb;

    modport master (
        input  rgb_in,
        output p_tick, pixel_x, pixel_y, video_on, line_start, frame_start,
        output hsync, vsync, rgb
    );

    modport slave (
        output rgb_in,
        input  p_tick, pixel_x, pixel_y, video_on, line_start, frame_start,
        input  hsync, vsync, rgb
    );
endinterface

// File: rtl/vga_tick_div.sv
// Divides the system clock into a one-clk pixel tick every DIV clocks.
module vga_tick_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] divCnt_q;
    logic [DW-1:0] divCnt_d;

    always_comb begin
        divCnt_d = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_d;
        end
    end

    // Gating with reset keeps the tick quiet in reset even when DIV=1.
    assign p_tick = reset & (divCnt_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA timing generator: pixel counters, sync pulses and a one-pixel
// output stage that keeps rgb, hsync and vsync aligned to the same pixel.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int DIV       = 2,
    parameter int SYNC_POL  = 0,
    parameter int CNT_W     = 10,
    parameter int RGB_W     = VGA_RGB_W
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master bus
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic SYNC_ACTIVE = (SYNC_POL != 0);

    logic             pTick;
    logic             videoOn;
    logic [CNT_W-1:0] pixelX_q, pixelX_d;
    logic [CNT_W-1:0] pixelY_q, pixelY_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    vga_tick_div #(.DIV(DIV)) uTickDiv (
        .clk    (clk),
        .reset  (reset),
        .p_tick (pTick)
    );

    assign videoOn = (int'(pixelX_q) < H_DISPLAY) && (int'(pixelY_q) < V_DISPLAY);

    always_comb begin
        pixelX_d = pixelX_q + 1'b1;
        pixelY_d = pixelY_q;
        if (pixelX_q == H_LAST) begin
            pixelX_d = '0;
            pixelY_d = (pixelY_q == V_LAST) ? '0 : pixelY_q + 1'b1;
        end
    end

    // Output stage is computed from the pre-increment position so it lags one pixel.
    always_comb begin
        rgb_d   = videoOn ? bus.rgb_in : '0;
        hsync_d = inWindow(int'(pixelX_q), H_DISPLAY + H_FRONT, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = inWindow(int'(pixelY_q), V_DISPLAY + V_FRONT, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixelX_q <= '0;
            pixelY_q <= '0;
            hsync_q  <= ~SYNC_ACTIVE;
            vsync_q  <= ~SYNC_ACTIVE;
            rgb_q    <= '0;
        end else if (pTick) begin
            pixelX_q <= pixelX_d;
            pixelY_q <= pixelY_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            rgb_q    <= rgb_d;
        end
    end

    assign bus.p_tick      = pTick;
    assign bus.pixel_x     = pixelX_q;
    assign bus.pixel_y     = pixelY_q;
    assign bus.video_on    = videoOn;
    assign bus.line_start  = pTick && (pixelX_q == '0);
    assign bus.frame_start = pTick && (pixelX_q == '0) && (pixelY_q == '0);
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.rgb         = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: DUT A uses default timing (DIV=2, active-low sync),
// DUT B uses a short 8-line frame with DIV=1 and active-high sync.
module tb_vga_sync_gen;
    import vga_pkg::*;

    localparam int P_HD  [2] = '{640, 640};
    localparam int P_HF  [2] = '{16, 16};
    localparam int P_HS  [2] = '{96, 96};
    localparam int P_HB  [2] = '{48, 48};
    localparam int P_VD  [2] = '{480, 4};
    localparam int P_VF  [2] = '{10, 1};
    localparam int P_VS  [2] = '{2, 2};
    localparam int P_VB  [2] = '{33, 1};
    localparam int P_DIV [2] = '{2, 1};
    localparam int P_POL [2] = '{0, 1};

    typedef struct packed {
        logic [2:0] rgb;
        logic       hsync;
        logic       vsync;
    } pix_t;

    typedef struct {
        int pt; int px; int py; int von; int ls; int fs; int hs; int vs; int rgb;
    } obs_t;

    logic       clk = 1'b0;
    logic [1:0] resetN;
    int         cyc = 0;
    int         passCount = 0;
    int         checkCount = 0;

    pix_t       sbQ [2][$];
    pix_t       held [2];
    int         mDiv [2], mX [2], mY [2];
    logic       mTickPrev [2];
    logic       prevH [2], prevV [2];
    int         lastHAct [2], lastVAct [2], lastFs [2], lsCount [2], rgbCount [2];

    always #5 clk = ~clk;

    vga_sync_gen_if #(.CNT_W(10), .RGB_W(3)) busA ();
    vga_sync_gen_if #(.CNT_W(10), .RGB_W(3)) busB ();

    vga_sync_gen #(
        .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_DISPLAY(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
        .DIV(2), .SYNC_POL(0), .CNT_W(10), .RGB_W(3)
    ) dutA (
        .clk   (clk),
        .reset (resetN[0]),
        .bus   (busA.master)
    );

    vga_sync_gen #(
        .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .DIV(1), .SYNC_POL(1), .CNT_W(10), .RGB_W(3)
    ) dutB (
        .clk   (clk),
        .reset (resetN[1]),
        .bus   (busB.master)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic readObs(input int d, output obs_t o);
        if (d == 0) begin
            o.pt = busA.p_tick; o.px = busA.pixel_x; o.py = busA.pixel_y; o.von = busA.video_on;
            o.ls = busA.line_start; o.fs = busA.frame_start; o.hs = busA.hsync; o.vs = busA.vsync; o.rgb = busA.rgb;
        end else begin
            o.pt = busB.p_tick; o.px = busB.pixel_x; o.py = busB.pixel_y; o.von = busB.video_on;
            o.ls = busB.line_start; o.fs = busB.frame_start; o.hs = busB.hsync; o.vs = busB.vsync; o.rgb = busB.rgb;
        end
    endtask

    // Returns the reference model to its reset state and clears the scoreboard.
    task automatic modelReset(input int d);
        logic inact;
        inact = (P_POL[d] == 0);
        mDiv[d] = 0; mX[d] = 0; mY[d] = 0; mTickPrev[d] = 1'b0;
        sbQ[d].delete();
        held[d] = '{rgb: 3'b000, hsync: inact, vsync: inact};
        prevH[d] = inact; prevV[d] = inact;
        lastHAct[d] = -1; lastVAct[d] = -1; lastFs[d] = -1; lsCount[d] = 0; rgbCount[d] = 0;
    endtask

    function automatic logic expTick(input int d);
        return resetN[d] && (mDiv[d] == P_DIV[d] - 1);
    endfunction

    // Compares one DUT against the model and updates the timing measurements.
    task automatic checkDut(input int d);
        obs_t  o;
        string n;
        int    tick, vis, pol;
        n    = (d == 0) ? "A" : "B";
        pol  = P_POL[d];
        tick = int'(expTick(d));
        vis  = int'((mX[d] < P_HD[d]) && (mY[d] < P_VD[d]));
        if (mTickPrev[d]) begin
            if (sbQ[d].size() > 0) held[d] = sbQ[d].pop_front();
            else checkOutput({n, ".scoreboard_empty"}, 0, 1);
            mTickPrev[d] = 1'b0;
        end
        readObs(d, o);
        checkOutput({n, ".p_tick"}, o.pt, tick);
        checkOutput({n, ".pixel_x"}, o.px, mX[d]);
        checkOutput({n, ".pixel_y"}, o.py, mY[d]);
        checkOutput({n, ".video_on"}, o.von, vis);
        checkOutput({n, ".line_start"}, o.ls, int'(tick == 1 && mX[d] == 0));
        checkOutput({n, ".frame_start"}, o.fs, int'(tick == 1 && mX[d] == 0 && mY[d] == 0));
        checkOutput({n, ".hsync"}, o.hs, int'(held[d].hsync));
        checkOutput({n, ".vsync"}, o.vs, int'(held[d].vsync));
        checkOutput({n, ".rgb"}, o.rgb, int'(held[d].rgb));

        if (o.rgb != 0) rgbCount[d]++;
        if (o.hs == pol && prevH[d] != pol) begin
            checkOutput({n, ".hsync_start_x"}, o.px, P_HD[d] + P_HF[d] + 1);
            if (lastHAct[d] >= 0) begin
                checkOutput({n, ".line_period"}, cyc - lastHAct[d], 800 * P_DIV[d]);
                if (d == 0) checkOutput({n, ".visible_clks"}, rgbCount[d], P_HD[d] * P_DIV[d]);
            end
            rgbCount[d] = 0;
            lastHAct[d] = cyc;
        end else if (o.hs != pol && prevH[d] == pol && lastHAct[d] >= 0) begin
            checkOutput({n, ".hsync_width"}, cyc - lastHAct[d], P_HS[d] * P_DIV[d]);
        end
        if (o.vs == pol && prevV[d] != pol) begin
            checkOutput({n, ".vsync_start_y"}, o.py, P_VD[d] + P_VF[d]);
            lastVAct[d] = cyc;
        end else if (o.vs != pol && prevV[d] == pol && lastVAct[d] >= 0) begin
            checkOutput({n, ".vsync_width"}, cyc - lastVAct[d], P_VS[d] * 800 * P_DIV[d]);
        end
        if (o.fs != 0) begin
            if (lastFs[d] >= 0) begin
                checkOutput({n, ".frame_period"}, cyc - lastFs[d], 800 * (P_VD[d] + P_VF[d] + P_VS[d] + P_VB[d]) * P_DIV[d]);
                checkOutput({n, ".lines_per_frame"}, lsCount[d], P_VD[d] + P_VF[d] + P_VS[d] + P_VB[d]);
            end
            lsCount[d] = 0;
            lastFs[d] = cyc;
        end
        if (o.ls != 0) lsCount[d]++;
        prevH[d] = o.hs[0];
        prevV[d] = o.vs[0];
    endtask

    // Steps the model across the coming clock edge, pushing the expected output pixel.
    task automatic modelAdvance(input int d, input logic [2:0] rgbIn);
        pix_t p;
        logic pol;
        if (!resetN[d]) return;
        pol = (P_POL[d] != 0);
        if (expTick(d)) begin
            p.rgb   = ((mX[d] < P_HD[d]) && (mY[d] < P_VD[d])) ? rgbIn : 3'b000;
            p.hsync = ((mX[d] >= P_HD[d] + P_HF[d]) && (mX[d] < P_HD[d] + P_HF[d] + P_HS[d])) ? pol : ~pol;
            p.vsync = ((mY[d] >= P_VD[d] + P_VF[d]) && (mY[d] < P_VD[d] + P_VF[d] + P_VS[d])) ? pol : ~pol;
            sbQ[d].push_back(p);
            mTickPrev[d] = 1'b1;
            mX[d]++;
            if (mX[d] == P_HD[d] + P_HF[d] + P_HS[d] + P_HB[d]) begin
                mX[d] = 0;
                mY[d]++;
                if (mY[d] == P_VD[d] + P_VF[d] + P_VS[d] + P_VB[d]) mY[d] = 0;
            end
        end
        mDiv[d] = (mDiv[d] == P_DIV[d] - 1) ? 0 : mDiv[d] + 1;
    endtask

    // Drives one cycle of inputs at the falling edge, checks, then advances the model.
    task automatic applyStimulus(input logic [1:0] rst, input logic [2:0] rgbA, input logic [2:0] rgbB);
        @(negedge clk);
        cyc++;
        resetN = rst;
        busA.rgb_in = rgbA;
        busB.rgb_in = rgbB;
        for (int d = 0; d < 2; d++) if (!rst[d]) modelReset(d);
        #1;
        for (int d = 0; d < 2; d++) checkDut(d);
        modelAdvance(0, rgbA);
        modelAdvance(1, rgbB);
    endtask

    initial begin
        int budget;
        resetN = 2'b00;
        busA.rgb_in = 3'b111;
        busB.rgb_in = 3'b111;
        modelReset(0);
        modelReset(1);

        for (int i = 0; i < 5; i++) applyStimulus(2'b00, COLOUR_WHITE, COLOUR_WHITE);

        for (int i = 0; i < 13000; i++) applyStimulus(2'b11, COLOUR_MAGENTA, 3'($urandom_range(7)));

        budget = 0;
        while (!(mX[1] == 300 && mY[1] == 5) && budget < 8000) begin
            applyStimulus(2'b11, COLOUR_MAGENTA, 3'($urandom_range(7)));
            budget++;
        end
        checkOutput("B.reach_reset_point", int'(mX[1] == 300 && mY[1] == 5), 1);

        for (int i = 0; i < 3; i++) applyStimulus(2'b01, COLOUR_MAGENTA, 3'($urandom_range(7)));
        for (int i = 0; i < 14000; i++) applyStimulus(2'b11, COLOUR_MAGENTA, 3'($urandom_range(7)));

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
